// File: rtl/dmem_lat.sv
// dmem_lat: data memory behind the MEM stage with byte/halfword/word
// loads and stores, a fixed access latency and ready/valid handshakes.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_we             1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned       zero-extend sub-word loads
//   req_addr           byte address
//   req_wdata          right-aligned store data
//   resp_valid/ready   response handshake
//   resp_rdata         extended load data, 0 for stores and errors
//   resp_err           request was rejected (misaligned/out of range/bad size)
//
// state  | meaning
// IDLE   | waiting for a request, req_ready = 1
// WAIT   | request captured, counting down the access latency
// RESP   | response held until resp_ready
module dmem_lat #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  // Contents are deliberately not reset.
  logic [31:0]      mem [DEPTH];

  logic             access;
  logic             acc_err;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      ld_data;
  logic [31:0]      st_data;
  logic [3:0]       st_be;

  assign access  = (state_q == S_WAIT) && (cnt_q == '0);
  assign mem_idx = addr_q[IDX_W+1:2];
  assign rd_word = mem[mem_idx];
  assign mem_we  = access && we_q && !acc_err;

  // Access decode works only from the captured request.
  always_comb begin
    acc_err = 1'b0;
    rd_byte = 8'h00;
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = 32'h0;
    st_data = wdata_q;
    st_be   = 4'h0;

    // Full 30-bit word index compare so high address bits never alias.
    if ({2'b00, addr_q[31:2]} >= 32'(DEPTH)) acc_err = 1'b1;

    case (addr_q[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase

    case (size_q)
      2'b00: begin
        ld_data = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        st_data = {4{wdata_q[7:0]}};
        st_be   = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        if (addr_q[0]) acc_err = 1'b1;
        ld_data = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
        st_data = {2{wdata_q[15:0]}};
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        if (addr_q[1:0] != 2'b00) acc_err = 1'b1;
        ld_data = rd_word;
        st_be   = 4'hF;
      end
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? 32'h0 : ld_data;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[mem_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_lat.sv
// Bench for dmem_lat: directed scenarios with literal expectations plus a
// randomized run, all checked cycle by cycle against a byte-array model.
module tb_dmem_lat;

  localparam int DEPTH   = 128;
  localparam int LATENCY = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_lat #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mb [4*DEPTH];
  bit         mk [4*DEPTH];

  bit          m_busy, m_valid;
  int          m_since;
  logic        p_we, p_uns;
  logic [1:0]  p_size;
  logic [31:0] p_addr, p_wdata;
  logic        exp_err;
  logic [31:0] exp_rdata;
  bit          exp_known;

  function automatic bit f_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
           || ((a >> 2) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] f_load_val(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int nb = 1 << sz;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[int'(a) + i];
    if (!uns && sz == 2'b00) v = {{24{v[7]}}, v[7:0]};
    if (!uns && sz == 2'b01) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  function automatic bit f_load_known(input logic [1:0] sz, input logic [31:0] a);
    bit kn = 1'b1;
    int nb = 1 << sz;
    for (int i = 0; i < nb; i++) kn = kn & mk[int'(a) + i];
    return kn;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_since <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        p_we    <= req_we;
        p_uns   <= req_unsigned;
        p_size  <= req_size;
        p_addr  <= req_addr;
        p_wdata <= req_wdata;
        m_busy  <= 1'b1;
        m_since <= 0;
      end
    end else if (!m_valid) begin
      if (m_since + 1 == LATENCY) begin
        m_valid   <= 1'b1;
        exp_err   <= f_err(p_size, p_addr);
        if (f_err(p_size, p_addr) || p_we) begin
          exp_rdata <= 32'h0;
          exp_known <= 1'b1;
        end else begin
          exp_rdata <= f_load_val(p_size, p_uns, p_addr);
          exp_known <= f_load_known(p_size, p_addr);
        end
        if (!f_err(p_size, p_addr) && p_we) begin
          for (int i = 0; i < (1 << p_size); i++) begin
            mb[int'(p_addr) + i] <= p_wdata[8*i +: 8];
            mk[int'(p_addr) + i] <= 1'b1;
          end
        end
      end
      m_since <= m_since + 1;
    end else if (resp_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_err", resp_err, 0);
    end else begin
      chk("req_ready", req_ready, !m_busy);
      chk("resp_valid", resp_valid, m_valid);
      if (m_valid) begin
        chk("resp_err", resp_err, exp_err);
        if (exp_known) chk("resp_rdata", resp_rdata, exp_rdata);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int hold, input bit pulse,
                     output logic [31:0] rd, output logic er, output int lat);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("wait_req_ready", req_ready, 1);
    #1;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(negedge clk);
    #1;
    // Scramble inputs after acceptance; only the captured request matters.
    req_valid    = 1'b0;
    req_we       = 1'($urandom_range(0, 1));
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_addr     = $urandom;
    req_wdata    = $urandom;
    k = 0;
    while (!resp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait_resp_valid", resp_valid, 1);
    lat = k;
    rd  = resp_rdata;
    er  = resp_err;
    for (int i = 0; i < hold; i++) begin
      #1;
      req_valid = pulse && (i == 1);
      req_addr  = $urandom;
      @(negedge clk);
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rdata_stable", resp_rdata, rd);
      chk("bp_err_stable", resp_err, er);
    end
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_release", req_ready, 1);
    #1;
    resp_ready = 1'b0;
  endtask

  logic [31:0] rd, a;
  logic        er;
  int          lat;
  logic [1:0]  sz;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset in WAIT aborts a store.
    txn(1, 2'b10, 0, 32'h10, 32'h0BADF00D, 0, 0, rd, er, lat);
    @(negedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_busy", req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_rdata", resp_rdata, 0);
    chk("abort_err", resp_err, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    txn(0, 2'b10, 0, 32'h10, 0, 0, 0, rd, er, lat);
    chk("abort_kept_old", rd, 32'h0BADF00D);

    // Word store, latency, readback.
    txn(1, 2'b10, 0, 32'h8, 32'h12345678, 0, 0, rd, er, lat);
    chk("sw_latency", lat, LATENCY);
    chk("sw_err", er, 0);
    chk("sw_rdata", rd, 0);
    txn(0, 2'b10, 0, 32'h8, 0, 0, 0, rd, er, lat);
    chk("lw_8", rd, 32'h12345678);

    // Byte store and byte loads.
    txn(1, 2'b00, 0, 32'h9, 32'h000000AB, 0, 0, rd, er, lat);
    txn(0, 2'b10, 0, 32'h8, 0, 0, 0, rd, er, lat);
    chk("sb_lw", rd, 32'h1234AB78);
    txn(0, 2'b00, 0, 32'h9, 0, 0, 0, rd, er, lat);
    chk("lb_9", rd, 32'hFFFFFFAB);
    txn(0, 2'b00, 1, 32'h9, 0, 0, 0, rd, er, lat);
    chk("lbu_9", rd, 32'h000000AB);

    // Half store and half loads.
    txn(1, 2'b01, 0, 32'hA, 32'h00008001, 0, 0, rd, er, lat);
    txn(0, 2'b10, 0, 32'h8, 0, 0, 0, rd, er, lat);
    chk("sh_lw", rd, 32'h8001AB78);
    txn(0, 2'b01, 0, 32'hA, 0, 0, 0, rd, er, lat);
    chk("lh_a", rd, 32'hFFFF8001);
    txn(0, 2'b01, 1, 32'hA, 0, 0, 0, rd, er, lat);
    chk("lhu_a", rd, 32'h00008001);

    // Error cases leave neighbours intact.
    txn(1, 2'b10, 0, 32'h0, 32'h11110000, 0, 0, rd, er, lat);
    txn(1, 2'b10, 0, 32'h4, 32'h44444444, 0, 0, rd, er, lat);
    txn(1, 2'b10, 0, 32'(4*DEPTH-4), 32'h5A5A5A5A, 0, 0, rd, er, lat);
    txn(0, 2'b10, 0, 32'h6, 0, 0, 0, rd, er, lat);
    chk("err_lw6_err", er, 1);
    chk("err_lw6_rdata", rd, 0);
    txn(1, 2'b01, 0, 32'h3, 32'h0000FFFF, 0, 0, rd, er, lat);
    chk("err_sh3_err", er, 1);
    txn(0, 2'b11, 0, 32'h8, 0, 0, 0, rd, er, lat);
    chk("err_size3_err", er, 1);
    chk("err_size3_rdata", rd, 0);
    txn(1, 2'b10, 0, 32'(4*DEPTH), 32'hFFFFFFFF, 0, 0, rd, er, lat);
    chk("err_oob_err", er, 1);
    txn(1, 2'b10, 0, 32'h80000008, 32'hFFFFFFFF, 0, 0, rd, er, lat);
    chk("err_alias_err", er, 1);
    txn(0, 2'b10, 0, 32'h0, 0, 0, 0, rd, er, lat);
    chk("err_keep_0", rd, 32'h11110000);
    txn(0, 2'b10, 0, 32'h4, 0, 0, 0, rd, er, lat);
    chk("err_keep_4", rd, 32'h44444444);
    txn(0, 2'b10, 0, 32'h8, 0, 0, 0, rd, er, lat);
    chk("err_keep_8", rd, 32'h8001AB78);
    txn(0, 2'b10, 0, 32'(4*DEPTH-4), 0, 0, 0, rd, er, lat);
    chk("err_keep_last", rd, 32'h5A5A5A5A);

    // Back-pressure with an ignored request pulse.
    txn(0, 2'b10, 0, 32'h8, 0, 5, 1, rd, er, lat);
    chk("bp_rdata", rd, 32'h8001AB78);
    txn(0, 2'b10, 0, 32'h4, 0, 0, 0, rd, er, lat);
    chk("bp_after", rd, 32'h44444444);

    // Fill memory, then random traffic.
    for (int w = 0; w < DEPTH; w++) begin
      txn(1, 2'b10, 0, 32'(4*w), $urandom, 0, 0, rd, er, lat);
    end
    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 4*DEPTH-1));
      if ($urandom_range(0, 1) == 1) a = a & ~((32'h1 << sz) - 32'h1);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
          $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, er, lat);
      chk("rand_latency", lat, LATENCY);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
